// File: rtl/priority_dec_collector.sv
`default_nettype none
// =============================================================================
// priority_dec_collector: decodes a stream of encoded indices into a one-hot
// bitmap frame, closed by the index flagged last.   Rev 1.0
// =============================================================================
module priority_dec_collector #(
  parameter int IDX_W = 3,
  localparam int N = 2 ** IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic             idx_valid,
  input  logic             idx_last,
  output logic             idx_ready,
  output logic [N-1:0]     vec,
  output logic [IDX_W:0]   vec_cnt,
  output logic             vec_dup,
  output logic             vec_valid,
  input  logic             vec_ready
);

  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(N);
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [IDX_W:0] cnt_q, cnt_d;
  logic           dup_q, dup_d;

  logic           w_accept;
  logic [N-1:0]   w_onehot;

  assign idx_ready = en & (state_q != HOLD);
  assign w_accept  = idx_valid & idx_ready;
  assign w_onehot  = N'(1) << idx;

  assign vec       = acc_q;
  assign vec_cnt   = cnt_q;
  assign vec_dup   = dup_q;
  assign vec_valid = (state_q == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dup_q   <= dup_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dup_d   = dup_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          acc_d   = w_onehot;
          cnt_d   = CNT_ONE;
          dup_d   = 1'b0;
          state_d = idx_last ? HOLD : COLLECT;
        end
      end
      COLLECT: begin
        if (w_accept) begin
          // Duplicate detection must look at the bitmap before this index lands.
          acc_d   = acc_q | w_onehot;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          dup_d   = dup_q | acc_q[idx];
          state_d = idx_last ? HOLD : COLLECT;
        end
      end
      HOLD: begin
        if (vec_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          dup_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_priority_dec_collector.sv
`default_nettype none
// Self-checking bench for priority_dec_collector: directed scenarios plus
// randomized frames compared against a set-based frame model.
module tb_priority_dec_collector;

  logic       clk = 1'b0;
  logic       rst_n, en, idx_valid, idx_last, vec_ready;
  logic [2:0] idx;
  logic       idx_ready, vec_dup, vec_valid;
  logic [7:0] vec;
  logic [3:0] vec_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  priority_dec_collector #(.IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .idx(idx), .idx_valid(idx_valid),
    .idx_last(idx_last), .idx_ready(idx_ready), .vec(vec), .vec_cnt(vec_cnt),
    .vec_dup(vec_dup), .vec_valid(vec_valid), .vec_ready(vec_ready)
  );

  // Frame model: {valid, bitmap, count, dup} from the list of indices sent.
  function automatic logic [13:0] model(input int q[$]);
    logic [7:0] v = '0;
    int         c = 0;
    logic       d = 1'b0;
    foreach (q[k]) begin
      if (v[q[k]]) d = 1'b1;
      v[q[k]] = 1'b1;
      c++;
    end
    if (c > 8) c = 8;
    return {1'b1, v, 4'(c), d};
  endfunction

  // Presents one index and returns #1 after the edge that accepted it.
  task automatic send(input int i, input logic l);
    int guard = 0;
    idx = 3'(i); idx_last = l; idx_valid = 1'b1;
    @(negedge clk);
    while (!idx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      $display("FAIL send_timeout idx=%0d idx_ready stuck at %b, required 1", i, idx_ready);
    end
    @(posedge clk); #1;
    idx_valid = 1'b0;
  endtask

  task automatic send_frame(input int q[$]);
    foreach (q[k]) send(q[k], k == q.size() - 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; idx = 3'd6; idx_valid = 1'b1; idx_last = 1'b1; vec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({vec_valid, vec, vec_cnt, vec_dup, idx_ready} !== {1'b0, 8'h00, 4'd0, 1'b0, 1'b1})
      $display("FAIL reset_state got v=%b vec=%h cnt=%0d dup=%b rdy=%b, required 0 00 0 0 1",
               vec_valid, vec, vec_cnt, vec_dup, idx_ready);
    else n_pass++;
    idx_valid = 1'b0; idx_last = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    vec_ready = 1'b1;
    send_frame('{7, 2, 0});
    n_checks++;
    if ({vec_valid, vec, vec_cnt, vec_dup, idx_ready} !== {1'b1, 8'h85, 4'd3, 1'b0, 1'b0})
      $display("FAIL basic_frame got v=%b vec=%h cnt=%0d dup=%b rdy=%b, required 1 85 3 0 0",
               vec_valid, vec, vec_cnt, vec_dup, idx_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({vec_valid, idx_ready} !== 2'b01)
      $display("FAIL basic_drain got v=%b rdy=%b, required v=0 rdy=1", vec_valid, idx_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    vec_ready = 1'b1;
    send(5, 1'b1);
    n_checks++;
    if ({vec_valid, vec, vec_cnt, vec_dup} !== {1'b1, 8'h20, 4'd1, 1'b0})
      $display("FAIL single_index got v=%b vec=%h cnt=%0d dup=%b, required 1 20 1 0",
               vec_valid, vec, vec_cnt, vec_dup);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_dup();
    vec_ready = 1'b1;
    send_frame('{3, 3, 6});
    n_checks++;
    if ({vec_valid, vec, vec_cnt, vec_dup} !== {1'b1, 8'h48, 4'd3, 1'b1})
      $display("FAIL dup_frame got v=%b vec=%h cnt=%0d dup=%b, required 1 48 3 1",
               vec_valid, vec, vec_cnt, vec_dup);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    vec_ready = 1'b0;
    send_frame('{1, 2});
    for (int c = 0; c < 5; c++) begin
      idx = 3'($urandom_range(0, 7)); idx_last = 1'($urandom); idx_valid = c[0];
      @(posedge clk); #1;
      n_checks++;
      if ({vec_valid, vec, vec_cnt, vec_dup, idx_ready} !== {1'b1, 8'h06, 4'd2, 1'b0, 1'b0})
        $display("FAIL backpressure_hold cyc=%0d got v=%b vec=%h cnt=%0d dup=%b rdy=%b, required 1 06 2 0 0",
                 c, vec_valid, vec, vec_cnt, vec_dup, idx_ready);
      else n_pass++;
    end
    idx_valid = 1'b0; vec_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({vec_valid, idx_ready} !== 2'b01)
      $display("FAIL backpressure_release got v=%b rdy=%b, required v=0 rdy=1", vec_valid, idx_ready);
    else n_pass++;
  endtask

  task automatic test_enable();
    vec_ready = 1'b1;
    send(1, 1'b0);
    en = 1'b0; idx = 3'd4; idx_last = 1'b1; idx_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({idx_ready, vec_valid} !== 2'b00)
        $display("FAIL enable_low cyc=%0d got rdy=%b v=%b, required rdy=0 v=0", c, idx_ready, vec_valid);
      else n_pass++;
      @(posedge clk); #1;
    end
    en = 1'b1;
    send(4, 1'b1);
    n_checks++;
    if ({vec_valid, vec, vec_cnt, vec_dup} !== {1'b1, 8'h12, 4'd2, 1'b0})
      $display("FAIL enable_frame got v=%b vec=%h cnt=%0d dup=%b, required 1 12 2 0",
               vec_valid, vec, vec_cnt, vec_dup);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation_reset();
    vec_ready = 1'b1;
    send_frame('{0, 1, 2, 3, 4, 5, 6, 7, 0, 1});
    n_checks++;
    if ({vec_valid, vec, vec_cnt, vec_dup} !== {1'b1, 8'hFF, 4'd8, 1'b1})
      $display("FAIL saturation got v=%b vec=%h cnt=%0d dup=%b, required 1 ff 8 1",
               vec_valid, vec, vec_cnt, vec_dup);
    else n_pass++;
    @(posedge clk); #1;
    send(2, 1'b0);
    send(5, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({vec_valid, vec, vec_cnt, vec_dup, idx_ready} !== {1'b0, 8'h00, 4'd0, 1'b0, 1'b1})
      $display("FAIL midframe_reset got v=%b vec=%h cnt=%0d dup=%b rdy=%b, required 0 00 0 0 1",
               vec_valid, vec, vec_cnt, vec_dup, idx_ready);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      int q[$];
      int len;
      int wait_cyc;
      logic [13:0] exp;
      len = $urandom_range(1, 12);
      q = {};
      for (int k = 0; k < len; k++) q.push_back($urandom_range(0, 7));
      exp = model(q);
      vec_ready = 1'b0;
      foreach (q[k]) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send(q[k], k == len - 1);
      end
      wait_cyc = $urandom_range(0, 3);
      for (int c = 0; c <= wait_cyc; c++) begin
        if (c > 0) begin @(posedge clk); #1; end
        n_checks++;
        if ({vec_valid, vec, vec_cnt, vec_dup} !== exp)
          $display("FAIL random_frame f=%0d len=%0d got %h, required %h",
                   f, len, {vec_valid, vec, vec_cnt, vec_dup}, exp);
        else n_pass++;
      end
      vec_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (vec_valid !== 1'b0)
        $display("FAIL random_drain f=%0d got v=%b, required 0", f, vec_valid);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_dup();
    test_backpressure();
    test_enable();
    test_saturation_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/priority_dec_collector.md
Name: priority_dec_collector

Overview:
Sequential inverse of the team's 8:3 priority encoder. It accepts a stream of encoded indices over a valid/ready handshake and decodes each one to one-hot. It ORs the decoded bits into a bitmap and presents the bitmap as a frame when the index flagged "last" is accepted. It sits on the receive side of links that carry priority-encoded request indices, and rebuilds the original request vector for downstream logic.

Parameters:
IDX_W, 3, width of the encoded index; bitmap width N = 2**IDX_W (8 at default)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
en  input  1  block enable; low blocks new index acceptance
idx  input  IDX_W  encoded index (bit position to set)
idx_valid  input  1  idx/idx_last valid
idx_last  input  1  marks final index of a frame
idx_ready  output  1  block can accept an index this cycle
vec  output  N  assembled bitmap; bit k set if index k was received in the frame
vec_cnt  output  IDX_W+1  number of indices accepted in the frame, duplicates included, saturating at N
vec_dup  output  1  at least one index repeated within the frame
vec_valid  output  1  frame output valid
vec_ready  input  1  downstream accepts frame

Behaviour:
- Reset, rst_n low at a clock edge: state IDLE; vec=0, vec_cnt=0, vec_dup=0, vec_valid=0. Reset overrides all other inputs and discards any partial or held frame.
- Accept condition: idx_valid & idx_ready. Index transfer occurs at that edge.
- idx_ready = en & (state != HOLD). It is combinational from en and the state register.
- State IDLE:
  - On accept, acc <= onehot(idx), cnt <= 1, dup <= 0.
  - Next state is HOLD if idx_last, else COLLECT.
- State COLLECT:
  - On accept, acc <= acc | onehot(idx).
  - cnt <= min(cnt+1, N).
  - dup <= dup | acc[idx], using the pre-update acc.
  - Next state is HOLD if idx_last, else remains COLLECT.
  - No accept leaves all state unchanged.
- State HOLD:
  - vec_valid=1; vec/vec_cnt/vec_dup are stable until handshake.
  - On vec_valid & vec_ready, next state is IDLE and acc, cnt and dup are cleared.
  - idx_ready=0 throughout HOLD.
  - The first new index is accepted no earlier than the cycle after the handshake, so there is one bubble cycle per frame.
- Latency: index accepted with idx_last at edge t gives vec_valid=1 in the cycle after t. vec includes that index's bit.
- Outputs vec, vec_cnt and vec_dup are driven directly from the acc, cnt and dup registers in all states. They are only meaningful while vec_valid=1.
- en low:
  - In IDLE or COLLECT, no accept occurs; the partial frame is retained.
  - In HOLD, the frame still drains normally, because vec_ready is independent of en.
- vec_ready high outside HOLD has no effect.
- idx_valid while idx_ready=0 is ignored. The upstream holds idx/idx_last stable until accepted.
- cnt saturation: after N accepts, cnt stays N. Further accepts still update acc and dup.
- Single-index frame (first accept has idx_last=1): vec=onehot(idx), vec_cnt=1, vec_dup=0.
- All N index values are legal; there is no invalid encoding.

Test Plan:
1. Reset then frame idx 7, 2, 0 (last on 0), vec_ready=1 -> vec_valid rises the cycle after the idx 0 accept; vec=8'b1000_0101, vec_cnt=3, vec_dup=0; vec_valid drops the next cycle; idx_ready returns to 1 in IDLE.
2. Single index idx=5 with idx_last=1 -> vec=8'b0010_0000, vec_cnt=1, vec_dup=0.
3. Frame idx 3, 3, 6 (last on 6) -> vec=8'b0100_1000, vec_cnt=3, vec_dup=1.
4. Backpressure: complete frame with vec_ready=0 for 5 cycles -> vec_valid held high and vec constant; idx_ready=0; idx_valid pulses in this window are ignored; on vec_ready=1, IDLE follows.
5. en toggling: accept idx 1, drop en for 3 cycles with idx_valid=1 -> idx_ready=0, no accept; restore en and send idx 4 last -> vec=8'b0001_0010, vec_cnt=2.
6. Saturation and reset: send 10 indices cycling 0..7,0,1 (last on the 10th) -> vec=8'hFF, vec_cnt=8, vec_dup=1. Then rst_n low mid-frame after 2 accepts -> outputs all 0 next cycle and idx_ready=1.
